// File: rtl/dest_reg_pipe_pkg.sv
// Shared encodings for destination-register selection and operand forwarding
// in the MIPS destination-register pipeline.
package dest_reg_pipe_pkg;

    typedef enum logic [1:0] {
        REG_DST_RT = 2'd0,
        REG_DST_RD = 2'd1,
        REG_DST_RA = 2'd2
    } reg_dst_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_e;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/dest_reg_pipe_stage_ctl.sv
// One pipeline stage register holding {valid, reg_write, mem_read, dest};
// a bubble request loads all-zero control instead of the upstream stage.
module pipe_stage_ctl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bubble,
    input  logic              d_valid,
    input  logic              d_reg_write,
    input  logic              d_mem_read,
    input  logic [ADDR_W-1:0] d_dest,
    output logic              q_valid,
    output logic              q_reg_write,
    output logic              q_mem_read,
    output logic [ADDR_W-1:0] q_dest
);

    logic              valid_q,     valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic [ADDR_W-1:0] dest_q,      dest_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d     = d_valid;
        reg_write_d = d_reg_write;
        mem_read_d  = d_mem_read;
        dest_d      = d_dest;
        if (bubble) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            dest_d      = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            dest_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            dest_q      <= dest_d;
        end
    end

    assign q_valid     = valid_q;
    assign q_reg_write = reg_write_q;
    assign q_mem_read  = mem_read_q;
    assign q_dest      = dest_q;

endmodule

// File: rtl/dest_reg_pipe.sv
// Destination-register pipeline ID->EX->MEM->WB with load-use stall detection
// and EX operand forwarding selects.
module dest_reg_pipe
    import dest_reg_pipe_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int RA_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [1:0]        id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [ADDR_W-1:0] ex_dest,
    output logic [ADDR_W-1:0] mem_dest,
    output logic              mem_reg_write,
    output logic [ADDR_W-1:0] wb_dest,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              load_use_stall
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] RA   = ADDR_W'(RA_REG);

    logic [ADDR_W-1:0] id_dest;
    logic              id_we;

    always_comb begin
        case (id_reg_dst)
            REG_DST_RD: id_dest = id_rd;
            REG_DST_RA: id_dest = RA;
            default:    id_dest = id_rt;
        endcase
    end

    // Writes to $0 are dropped here so no later stage ever forwards or retires them.
    assign id_we = id_valid & id_reg_write & (id_dest != ZERO);

    logic              ex_valid,  ex_rw,  ex_mr;
    logic              mem_valid, mem_rw, mem_mr;
    logic              wb_valid,  wb_rw,  wb_mr;
    logic [ADDR_W-1:0] ex_dst, mem_dst, wb_dst;
    logic              ex_bubble;

    assign ex_bubble = load_use_stall | flush;

    pipe_stage_ctl #(.ADDR_W(ADDR_W)) u_ex (
        .clk(clk), .reset(reset), .bubble(ex_bubble),
        .d_valid(id_valid), .d_reg_write(id_we),
        .d_mem_read(id_valid & id_mem_read), .d_dest(id_dest),
        .q_valid(ex_valid), .q_reg_write(ex_rw),
        .q_mem_read(ex_mr), .q_dest(ex_dst)
    );

    pipe_stage_ctl #(.ADDR_W(ADDR_W)) u_mem (
        .clk(clk), .reset(reset), .bubble(flush),
        .d_valid(ex_valid), .d_reg_write(ex_rw),
        .d_mem_read(ex_mr), .d_dest(ex_dst),
        .q_valid(mem_valid), .q_reg_write(mem_rw),
        .q_mem_read(mem_mr), .q_dest(mem_dst)
    );

    pipe_stage_ctl #(.ADDR_W(ADDR_W)) u_wb (
        .clk(clk), .reset(reset), .bubble(1'b0),
        .d_valid(mem_valid), .d_reg_write(mem_rw),
        .d_mem_read(mem_mr), .d_dest(mem_dst),
        .q_valid(wb_valid), .q_reg_write(wb_rw),
        .q_mem_read(wb_mr), .q_dest(wb_dst)
    );

    // EX-only source fields used for forwarding.
    logic [ADDR_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic              ex_uses_rs_q, ex_uses_rs_d, ex_uses_rt_q, ex_uses_rt_d;

    always_comb begin
        ex_rs_d      = id_rs;
        ex_rt_d      = id_rt;
        ex_uses_rs_d = id_valid & id_uses_rs;
        ex_uses_rt_d = id_valid & id_uses_rt;
        if (ex_bubble) begin
            ex_rs_d      = '0;
            ex_rt_d      = '0;
            ex_uses_rs_d = 1'b0;
            ex_uses_rt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_uses_rs_q <= 1'b0;
            ex_uses_rt_q <= 1'b0;
        end else begin
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_uses_rs_q <= ex_uses_rs_d;
            ex_uses_rt_q <= ex_uses_rt_d;
        end
    end

    logic ex_load_live;
    assign ex_load_live   = ex_valid & ex_mr & (ex_dst != ZERO);
    assign load_use_stall = id_valid & ex_load_live &
                            ((id_uses_rs & (id_rs == ex_dst)) |
                             (id_uses_rt & (id_rt == ex_dst)));

    function automatic fwd_e fwd_sel(input logic uses, input logic [ADDR_W-1:0] src,
                                     input logic m_hit_en, input logic [ADDR_W-1:0] m_dst,
                                     input logic w_hit_en, input logic [ADDR_W-1:0] w_dst);
        fwd_e sel;
        sel = FWD_REG;
        if (uses && src != ZERO) begin
            if (m_hit_en && m_dst == src)      sel = FWD_MEM;
            else if (w_hit_en && w_dst == src) sel = FWD_WB;
        end
        return sel;
    endfunction

    logic mem_we, wb_we;
    assign mem_we = mem_valid & mem_rw;
    assign wb_we  = wb_valid & wb_rw;

    assign fwd_a = fwd_sel(ex_uses_rs_q, ex_rs_q, mem_we, mem_dst, wb_we, wb_dst);
    assign fwd_b = fwd_sel(ex_uses_rt_q, ex_rt_q, mem_we, mem_dst, wb_we, wb_dst);

    assign ex_dest       = ex_valid  ? ex_dst  : ZERO;
    assign mem_dest      = mem_valid ? mem_dst : ZERO;
    assign wb_dest       = wb_valid  ? wb_dst  : ZERO;
    assign mem_reg_write = mem_we;
    assign wb_reg_write  = wb_we;
    assign wb_mem_to_reg = wb_valid & wb_mr;

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Scoreboard bench for dest_reg_pipe: accepted instructions queue their
// expected WB results; scenario tasks check stage, forwarding and stall outputs.
module tb_dest_reg_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rs, id_uses_rt;
    logic [1:0] id_reg_dst;
    logic       id_reg_write, id_mem_read, flush;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic       mem_reg_write, wb_reg_write, wb_mem_to_reg;
    logic [1:0] fwd_a, fwd_b;
    logic       load_use_stall;

    always #5 clk = ~clk;

    dest_reg_pipe dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
        .wb_dest(wb_dest), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use_stall(load_use_stall)
    );

    typedef struct {
        int         due;
        logic [4:0] dest;
        logic       we;
        logic       m2r;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic urs, input logic urt, input logic [1:0] rdst,
                            input logic rw, input logic mr);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt; id_reg_dst = rdst;
        id_reg_write = rw; id_mem_read = mr;
    endtask

    // Expected retirement of the instruction now in ID, accepted at the next edge.
    task automatic expect_retire(input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [1:0] rdst, input logic rw, input logic mr);
        logic [4:0] d;
        case (rdst)
            2'd1:    d = rd;
            2'd2:    d = 5'd31;
            default: d = rt;
        endcase
        sb_q.push_back('{cyc + 3, d, rw && (d != 5'd0), mr});
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input logic [1:0] rdst,
                         input logic rw, input logic mr);
        drive_id(rs, rt, rd, urs, urt, rdst, rw, mr);
        expect_retire(rt, rd, rdst, rw, mr);
    endtask

    task automatic nop();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reg_dst = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0;
    endtask

    task automatic sb_check();
        if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (wb_reg_write !== e.we || wb_mem_to_reg !== e.m2r || wb_dest !== e.dest) begin
                n_fail++;
                $display("FAIL wb_retire cyc=%0d got dest=%0d we=%b m2r=%b want dest=%0d we=%b m2r=%b",
                         cyc, wb_dest, wb_reg_write, wb_mem_to_reg, e.dest, e.we, e.m2r);
            end
        end else begin
            n_checks++;
            if (wb_reg_write !== 1'b0 || wb_dest !== 5'd0 || wb_mem_to_reg !== 1'b0) begin
                n_fail++;
                $display("FAIL wb_idle cyc=%0d got dest=%0d we=%b m2r=%b want all 0",
                         cyc, wb_dest, wb_reg_write, wb_mem_to_reg);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sb_check();
    endtask

    task automatic drain();
        nop();
        repeat (3) step();
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({ex_dest, mem_dest, mem_reg_write, wb_dest, wb_reg_write, wb_mem_to_reg,
             fwd_a, fwd_b, load_use_stall} !== '0) begin
            n_fail++;
            $display("FAIL %s got ex=%0d mem=%0d mrw=%b wb=%0d wrw=%b m2r=%b fa=%0d fb=%0d st=%b want all 0",
                     name, ex_dest, mem_dest, mem_reg_write, wb_dest, wb_reg_write,
                     wb_mem_to_reg, fwd_a, fwd_b, load_use_stall);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        drive_id(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1,
                 2'($urandom), 1'b1, 1'b1);
        #1;
        check_all_zero("reset_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            drive_id(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1,
                     2'($urandom), 1'b1, 1'b1);
        end
        check_all_zero("reset_held");
        reset = 1'b0;
        sb_q.delete();
        issue(5'd0, 5'd1, 5'd8, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        nop();
        n_checks++;
        if (ex_dest !== 5'd8) begin
            n_fail++;
            $display("FAIL first_ex_dest got %0d want 8", ex_dest);
        end
        step();
        n_checks++;
        if (mem_dest !== 5'd8 || mem_reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL first_mem got dest=%0d we=%b want 8/1", mem_dest, mem_reg_write);
        end
        step();
        drain();
    endtask

    task automatic test_zero_dest();
        issue(5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        nop();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
                n_fail++;
                $display("FAIL zero_fwd i=%0d got fa=%0d fb=%0d want 0/0", i, fwd_a, fwd_b);
            end
            step();
        end
        drain();
    endtask

    task automatic test_jal();
        issue(5'd0, 5'd4, 5'd12, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
        step();
        nop();
        n_checks++;
        if (ex_dest !== 5'd31) begin
            n_fail++;
            $display("FAIL jal_ex_dest got %0d want 31", ex_dest);
        end
        step();
        step();
        drain();
    endtask

    task automatic test_fwd_priority();
        issue(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        issue(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        issue(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        nop();
        n_checks++;
        if (fwd_a !== 2'd2) begin
            n_fail++;
            $display("FAIL fwd_mem_prio got fwd_a=%0d want 2", fwd_a);
        end
        drain();
        issue(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        nop();
        step();
        issue(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        nop();
        n_checks++;
        if (fwd_a !== 2'd1 || fwd_b !== 2'd0) begin
            n_fail++;
            $display("FAIL fwd_wb got fa=%0d fb=%0d want 1/0", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_load_use();
        issue(5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        step();
        drive_id(5'd0, 5'd9, 5'd10, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (load_use_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall_on got %b want 1", load_use_stall);
        end
        step();
        n_checks++;
        if (ex_dest !== 5'd0 || mem_dest !== 5'd9 || load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_bubble got ex=%0d mem=%0d st=%b want 0/9/0",
                     ex_dest, mem_dest, load_use_stall);
        end
        expect_retire(5'd9, 5'd10, 2'd1, 1'b1, 1'b0);
        step();
        nop();
        n_checks++;
        if (fwd_b !== 2'd1 || ex_dest !== 5'd10) begin
            n_fail++;
            $display("FAIL lu_fwd got fb=%0d ex=%0d want 1/10", fwd_b, ex_dest);
        end
        drain();
    endtask

    task automatic test_flush_stall();
        issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        drive_id(5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        step();
        drive_id(5'd3, 5'd0, 5'd11, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        n_checks++;
        if (load_use_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL fs_stall got %b want 1", load_use_stall);
        end
        step();
        flush = 1'b0;
        nop();
        n_checks++;
        if (mem_reg_write !== 1'b0 || mem_dest !== 5'd0 || ex_dest !== 5'd0) begin
            n_fail++;
            $display("FAIL fs_killed got mrw=%b mem=%0d ex=%0d want 0/0/0",
                     mem_reg_write, mem_dest, ex_dest);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            issue(5'($urandom), 5'($urandom), 5'($urandom), 1'b0, 1'b0,
                  2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            step();
        end
        drain();
    endtask

    task automatic test_reset_midop();
        issue(5'd0, 5'd0, 5'd20, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        issue(5'd0, 5'd21, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        step();
        nop();
        reset = 1'b1;
        #1;
        check_all_zero("reset_midop");
        reset = 1'b0;
        sb_q.delete();
        drain();
    endtask

    initial begin
        nop();
        flush = 1'b0;
        reset = 1'b1;
        test_reset();
        test_zero_dest();
        test_jal();
        test_fwd_priority();
        test_load_use();
        test_flush_stall();
        test_back_to_back();
        test_reset_midop();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got %0d entries want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dest_reg_pipe.md
Name: dest_reg_pipe

Overview:
- Carries each instruction's 5-bit destination-register number and write controls from decode through the EX, MEM and WB stages of the MIPS pipeline.
- Selects the destination at decode: rt, rd, or $ra for jal.
- Produces forwarding selects for the EX operands and a load-use stall request.
- Sits directly upstream of the per-stage 5-bit destination registers and the register-file write port; its wb_* outputs drive those.

Parameters:
- ADDR_W, 5, register-number width.
- RA_REG, 31, destination used when reg_dst selects link.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all stage state.
- id_valid  input  1  decode holds a real instruction.
- id_rs  input  ADDR_W  decode source register rs.
- id_rt  input  ADDR_W  decode source register rt.
- id_rd  input  ADDR_W  decode rd field.
- id_uses_rs  input  1  instruction reads rs.
- id_uses_rt  input  1  instruction reads rt.
- id_reg_dst  input  2  0 = rt, 1 = rd, 2 = RA_REG, 3 = reserved (treated as rt).
- id_reg_write  input  1  instruction writes the register file.
- id_mem_read  input  1  instruction is a load.
- flush  input  1  branch/jump taken in EX; kill the EX-stage instruction.
- ex_dest  output  ADDR_W  EX-stage destination.
- mem_dest  output  ADDR_W  MEM-stage destination.
- mem_reg_write  output  1  MEM stage will write.
- wb_dest  output  ADDR_W  WB destination to the register-file write port.
- wb_reg_write  output  1  register-file write enable.
- wb_mem_to_reg  output  1  WB data comes from memory.
- fwd_a  output  2  EX operand A source: 0 = regfile, 1 = WB, 2 = MEM.
- fwd_b  output  2  EX operand B source, same encoding.
- load_use_stall  output  1  hold IF/ID and the PC this cycle.

Behaviour:
- Stage state: EX, MEM and WB each hold {valid, reg_write, mem_read, dest}. EX additionally holds {rs, rt, uses_rs, uses_rt}.
- Reset:
  - All valid, reg_write and mem_read bits are 0; all dest/rs/rt fields are 0.
  - Consequently every output is 0 during and after reset until the first capture.
- Destination select (combinational in ID):
  - dest = id_rt, id_rd or RA_REG per id_reg_dst.
  - Effective write enable = id_valid & id_reg_write & (dest != 0). Writes to $0 are never propagated.
- Normal clock edge:
  - EX captures ID, MEM captures EX, WB captures MEM.
  - Latency from decode to wb_reg_write is 3 cycles.
- load_use_stall (combinational):
  - Asserted when EX.valid & EX.mem_read & EX.dest != 0, and EX.dest matches id_rs (with id_uses_rs) or id_rt (with id_uses_rt).
  - Also requires id_valid.
  - While asserted: EX captures a bubble (all control 0) instead of ID; MEM and WB still advance.
- flush:
  - EX captures a bubble.
  - MEM captures a bubble, so the instruction currently in EX is killed.
  - WB still advances.
- Simultaneous flush and stall: flush wins. The result is identical to flush alone; load_use_stall still reflects the combinational condition.
- Forwarding (combinational, per EX operand src ∈ {EX.rs, EX.rt}, gated by the matching uses bit):
  - 2 if MEM.valid & MEM.reg_write & MEM.dest == src & src != 0.
  - Otherwise 1 if WB.valid & WB.reg_write & WB.dest == src & src != 0.
  - Otherwise 0. MEM has priority over WB.
- Bubbles:
  - Bubble stages output their dest field as 0.
  - wb_reg_write = WB.valid & WB.reg_write.
  - wb_mem_to_reg = WB.valid & WB.mem_read.
- Reset mid-operation: all in-flight entries are discarded immediately (asynchronous); no partial write occurs.

Decomposition:
- Shared package holds:
  - REG_DST_RT = 0, REG_DST_RD = 1, REG_DST_RA = 2.
  - FWD_REG = 0, FWD_WB = 1, FWD_MEM = 2.
  - ZERO_REG = 0.
- One sub-module, pipe_stage_ctl: a single stage register with asynchronous reset and a bubble input, instantiated three times.
- The hazard and forwarding logic stays in the top level.

Test Plan:
- Reset: assert reset with random inputs → all outputs 0; deassert, then id_rd = 8, reg_dst = 1, reg_write = 1 → wb_dest = 8 and wb_reg_write = 1 exactly 3 edges later.
- $0 suppression: reg_dst = 1, id_rd = 0, reg_write = 1 → wb_reg_write stays 0 throughout; fwd_a/fwd_b never nonzero.
- jal: reg_dst = 2 → ex_dest = 31 after 1 edge and wb_dest = 31 after 3 edges.
- Forward priority: instruction A writes $5, then B writes $5, then C reads rs = $5 → in C's EX cycle fwd_a = 2; a sequence A(write $5), nop, C(read $5) → fwd_a = 1.
- Load-use: a load to $9 in EX with ID reading rt = $9 → load_use_stall = 1 for one cycle; EX shows a bubble (ex_dest = 0); the next cycle the consumer gets fwd_b = 1.
- Flush plus stall: flush = 1 with a write-$3 instruction in EX while the stall condition is true → mem_reg_write = 0 next cycle, $3 never reaches WB, and the WB-stage instruction still retires.
